// File: rtl/debug_input_ctrl.sv
// Front-panel input conditioner: synchronises and debounces KEY/SW, emits press pulses and the single-step handshake.
// Optional feature macro: DEBUG_INPUT_STEP_EN (single-step mode and step_req/step_ack handshake).
module debug_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 900000,
    parameter int unsigned SW_WIDTH        = 10
) (
    input  logic                main_clk,
    input  logic                reset,
    input  logic [1:0]          KEY,
    input  logic [SW_WIDTH-1:0] SW,
    output logic [1:0]          key_level,
    output logic [1:0]          key_pressed,
    output logic [SW_WIDTH-1:0] sw_stable,
    output logic [3:0]          reg_select,
    output logic                single_step_mode,
    output logic                step_req,
    input  logic                step_ack
);

    localparam int unsigned NBITS = SW_WIDTH + 2;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Raw keys are active-low, so their synchroniser idles high (released).
    localparam logic [NBITS-1:0] SYNC_RST = {{SW_WIDTH{1'b0}}, 2'b11};

    logic [NBITS-1:0] sync_meta;
    logic [NBITS-1:0] sync_raw;
    logic [NBITS-1:0] sync_val;
    logic [NBITS-1:0] stable;
    logic [CNT_W-1:0] cnt [NBITS];
    logic [1:0]       key_level_q;
    logic [1:0]       key_rise_c;

    // Two-flop synchroniser on every raw pin.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            sync_meta <= SYNC_RST;
            sync_raw  <= SYNC_RST;
        end else begin
            sync_meta <= {SW, KEY};
            sync_raw  <= sync_meta;
        end
    end

    // Internal polarity: 1 = pressed / switch on.
    assign sync_val = {sync_raw[NBITS-1:2], ~sync_raw[1:0]};

    // Per-bit debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < int'(NBITS); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NBITS); i++) begin
                if (sync_val[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync_val[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign key_level  = stable[1:0];
    assign sw_stable  = stable[NBITS-1:2];
    assign reg_select = sw_stable[3:0];

    assign key_rise_c = key_level & ~key_level_q;

    // Registered one-cycle press pulse.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            key_level_q <= '0;
            key_pressed <= '0;
        end else begin
            key_level_q <= key_level;
            key_pressed <= key_rise_c;
        end
    end

`ifdef DEBUG_INPUT_STEP_EN
    // Mode toggle and step handshake; step evaluation always uses the pre-toggle mode.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            single_step_mode <= 1'b0;
            step_req         <= 1'b0;
        end else begin
            if (key_rise_c[1]) begin
                single_step_mode <= ~single_step_mode;
            end
            if (key_rise_c[1] && single_step_mode) begin
                step_req <= 1'b0;
            end else if (step_req) begin
                if (step_ack) begin
                    step_req <= 1'b0;
                end
            end else if (key_rise_c[0] && single_step_mode) begin
                step_req <= 1'b1;
            end
        end
    end
`else
    logic unused_step_ack;

    assign single_step_mode = 1'b0;
    assign step_req         = 1'b0;
    assign unused_step_ack  = step_ack;
`endif

endmodule

// File: tb/tb_debug_input_ctrl.sv
// Scoreboard bench for debug_input_ctrl with DEBOUNCE_CYCLES=4; step tests follow DEBUG_INPUT_STEP_EN.
module tb_debug_input_ctrl;

    localparam int unsigned D  = 4;
    localparam int unsigned SW = 10;

    localparam int F_KL   = 0;
    localparam int F_KP   = 1;
    localparam int F_SW   = 2;
    localparam int F_RS   = 3;
    localparam int F_MODE = 4;
    localparam int F_REQ  = 5;

    logic          main_clk;
    logic          reset;
    logic [1:0]    KEY;
    logic [SW-1:0] SW_in;
    logic [1:0]    key_level;
    logic [1:0]    key_pressed;
    logic [SW-1:0] sw_stable;
    logic [3:0]    reg_select;
    logic          single_step_mode;
    logic          step_req;
    logic          step_ack;

    debug_input_ctrl #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(SW)) dut (
        .main_clk        (main_clk),
        .reset           (reset),
        .KEY             (KEY),
        .SW              (SW_in),
        .key_level       (key_level),
        .key_pressed     (key_pressed),
        .sw_stable       (sw_stable),
        .reg_select      (reg_select),
        .single_step_mode(single_step_mode),
        .step_req        (step_req),
        .step_ack        (step_ack)
    );

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] val;
        string       name;
    } chk_t;

    typedef struct {
        int       cyc;
        logic [1:0] val;
    } pulse_t;

    chk_t   exp_q[$];
    pulse_t pulse_q[$];
    int     edge_n    = 0;
    int     total     = 0;
    int     bad       = 0;
    int     step_seen = 0;

    initial begin
        main_clk = 1'b0;
        forever #5 main_clk = ~main_clk;
    end

    always @(posedge main_clk) begin
        edge_n <= edge_n + 1;
        if (step_req && step_ack) step_seen <= step_seen + 1;
    end

    function automatic logic [31:0] get_field(int f);
        case (f)
            F_KL:    return 32'(key_level);
            F_KP:    return 32'(key_pressed);
            F_SW:    return 32'(sw_stable);
            F_RS:    return 32'(reg_select);
            F_MODE:  return 32'(single_step_mode);
            default: return 32'(step_req);
        endcase
    endfunction

    // Monitor: retire level expectations due this cycle and match every presented press pulse.
    always @(negedge main_clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= edge_n) begin
                total++;
                if (exp_q[i].cyc < edge_n) begin
                    bad++;
                    $display("FAIL %s: check at edge %0d was missed (now %0d)", exp_q[i].name, exp_q[i].cyc, edge_n);
                end else if (get_field(exp_q[i].fld) !== exp_q[i].val) begin
                    bad++;
                    $display("FAIL %s @%0d: got=%0h want=%0h", exp_q[i].name, edge_n, get_field(exp_q[i].fld), exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
        if (edge_n > 0 && key_pressed !== 2'b00) begin
            total++;
            if (pulse_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse @%0d: got=%b want=none", edge_n, key_pressed);
            end else begin
                pulse_t p;
                p = pulse_q.pop_front();
                if (p.cyc != edge_n || p.val !== key_pressed) begin
                    bad++;
                    $display("FAIL pulse @%0d: got=%b want=%b@%0d", edge_n, key_pressed, p.val, p.cyc);
                end
            end
        end else if (pulse_q.size() > 0 && pulse_q[0].cyc <= edge_n) begin
            pulse_t p;
            p = pulse_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_pulse @%0d: got=none want=%b", p.cyc, p.val);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge main_clk);
    endtask

    task automatic expect_at(input int dc, input int fld, input logic [31:0] v, input string nm);
        chk_t c;
        c.cyc  = edge_n + dc;
        c.fld  = fld;
        c.val  = v;
        c.name = nm;
        exp_q.push_back(c);
    endtask

    task automatic expect_pulse(input int dc, input logic [1:0] v);
        pulse_t p;
        p.cyc = edge_n + dc;
        p.val = v;
        pulse_q.push_back(p);
    endtask

    task automatic check(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, got, want);
        end
    endtask

    initial begin
        reset    = 1'b1;
        KEY      = 2'b11;
        SW_in    = '0;
        step_ack = 1'b0;
        tick(3);
        reset = 1'b0;
        expect_at(1, F_KL, 0, "rst_key_level");
        expect_at(1, F_KP, 0, "rst_key_pressed");
        expect_at(1, F_SW, 0, "rst_sw_stable");
        expect_at(1, F_RS, 0, "rst_reg_select");
        expect_at(1, F_MODE, 0, "rst_mode");
        expect_at(1, F_REQ, 0, "rst_step_req");
        tick(4);

        // Debounce latency on KEY[0]; release must not pulse.
        KEY = 2'b10;
        expect_at(5, F_KL, 32'h0, "kl_before_d");
        expect_at(6, F_KL, 32'h1, "kl_at_d");
        expect_pulse(7, 2'b01);
        expect_at(7, F_MODE, 0, "mode_idle");
        expect_at(7, F_REQ, 0, "req_no_mode");
        tick(10);
        KEY = 2'b11;
        expect_at(5, F_KL, 32'h1, "kl_release_before");
        expect_at(6, F_KL, 32'h0, "kl_release_at");
        tick(10);

        // Three-cycle glitch on SW[2] is rejected.
        SW_in = 10'h004;
        tick(3);
        SW_in = 10'h000;
        expect_at(3, F_SW, 0, "glitch_sw_mid");
        expect_at(6, F_SW, 0, "glitch_sw_late");
        expect_at(6, F_RS, 0, "glitch_rs");
        tick(8);
        SW_in = 10'h00B;
        expect_at(5, F_RS, 32'h0, "rs_before_d");
        expect_at(6, F_RS, 32'hB, "rs_B");
        expect_at(6, F_SW, 32'h00B, "sw_00B");
        tick(8);
        SW_in = 10'h000;
        expect_at(6, F_RS, 32'h0, "rs_clear");
        tick(8);

`ifdef DEBUG_INPUT_STEP_EN
        // Enter single-step mode.
        KEY = 2'b01;
        expect_pulse(7, 2'b10);
        expect_at(6, F_MODE, 0, "mode_before");
        expect_at(7, F_MODE, 1, "mode_on");
        tick(8);
        KEY = 2'b11;
        tick(8);
        // Step request, then a dropped second press, then ack.
        KEY = 2'b10;
        expect_pulse(7, 2'b01);
        expect_at(6, F_REQ, 0, "req_before");
        expect_at(7, F_REQ, 1, "req_set");
        tick(8);
        KEY = 2'b11;
        tick(8);
        KEY = 2'b10;
        expect_pulse(7, 2'b01);
        expect_at(8, F_REQ, 1, "req_pending_hold");
        tick(8);
        KEY = 2'b11;
        tick(8);
        expect_at(1, F_REQ, 1, "req_before_ack");
        tick(1);
        step_ack = 1'b1;
        expect_at(1, F_REQ, 0, "req_acked");
        expect_at(1, F_MODE, 1, "mode_after_ack");
        tick(1);
        step_ack = 1'b0;
        tick(3);
        check("one_step_seen", step_seen, 1);

        // Ack on the same edge as a new press: ack wins, press dropped.
        KEY = 2'b10;
        expect_pulse(7, 2'b01);
        expect_at(7, F_REQ, 1, "req_set2");
        tick(8);
        KEY = 2'b11;
        tick(8);
        KEY = 2'b10;
        expect_pulse(7, 2'b01);
        expect_at(6, F_REQ, 1, "req_before_sim");
        expect_at(7, F_REQ, 0, "ack_beats_press");
        expect_at(8, F_REQ, 0, "press_dropped");
        tick(6);
        step_ack = 1'b1;
        tick(1);
        step_ack = 1'b0;
        tick(1);
        KEY = 2'b11;
        tick(8);
        check("two_steps_seen", step_seen, 2);

        // Leaving single-step mode clears a pending request.
        KEY = 2'b10;
        expect_pulse(7, 2'b01);
        expect_at(7, F_REQ, 1, "req_set3");
        tick(8);
        KEY = 2'b11;
        tick(8);
        KEY = 2'b01;
        expect_pulse(7, 2'b10);
        expect_at(6, F_REQ, 1, "req_before_exit");
        expect_at(6, F_MODE, 1, "mode_before_exit");
        expect_at(7, F_REQ, 0, "req_cleared_exit");
        expect_at(7, F_MODE, 0, "mode_off");
        tick(8);
        KEY = 2'b11;
        tick(8);

        // Both keys together from mode 0: toggle applies, request uses old mode.
        KEY = 2'b00;
        expect_pulse(7, 2'b11);
        expect_at(7, F_MODE, 1, "both_mode_on");
        expect_at(7, F_REQ, 0, "both_no_req");
        expect_at(9, F_REQ, 0, "both_no_req_late");
        tick(8);
        KEY = 2'b11;
        tick(8);

        // Reset mid-debounce with a pending request.
        KEY = 2'b10;
        expect_pulse(7, 2'b01);
        expect_at(7, F_REQ, 1, "req_set4");
        tick(8);
        KEY   = 2'b11;
        SW_in = 10'h003;
        tick(4);
        reset = 1'b1;
        expect_at(1, F_KL, 0, "mid_rst_kl");
        expect_at(1, F_KP, 0, "mid_rst_kp");
        expect_at(1, F_SW, 0, "mid_rst_sw");
        expect_at(1, F_MODE, 0, "mid_rst_mode");
        expect_at(1, F_REQ, 0, "mid_rst_req");
        tick(2);
        reset = 1'b0;
        expect_at(5, F_SW, 32'h0, "post_rst_sw_before");
        expect_at(6, F_SW, 32'h003, "post_rst_sw");
        expect_at(6, F_RS, 32'h3, "post_rst_rs");
        expect_at(10, F_KL, 0, "post_rst_kl");
        expect_at(10, F_MODE, 0, "post_rst_mode");
        tick(10);
        SW_in = 10'h000;
        tick(8);
`else
        // Without the step feature: pulses still occur, mode/request stay 0, ack ignored.
        KEY = 2'b01;
        expect_pulse(7, 2'b10);
        expect_at(7, F_MODE, 0, "nostep_mode");
        expect_at(8, F_MODE, 0, "nostep_mode_late");
        tick(8);
        KEY = 2'b11;
        tick(8);
        KEY = 2'b10;
        expect_pulse(7, 2'b01);
        expect_at(7, F_REQ, 0, "nostep_req");
        expect_at(8, F_REQ, 0, "nostep_req_late");
        tick(6);
        step_ack = 1'b1;
        tick(1);
        step_ack = 1'b0;
        expect_at(1, F_REQ, 0, "nostep_req_ack");
        tick(1);
        KEY = 2'b11;
        tick(8);
        check("nostep_steps", step_seen, 0);
`endif

        tick(2);
        check("exp_queue_drained", exp_q.size(), 0);
        check("pulse_queue_drained", pulse_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
